ringoscillator_freqmeter: RTL and testbench

RINGOSCILLATOR_FREQMETER -- requirements
Module: ringoscillator_freqmeter

---
 rtl/ringoscillator_pkg.sv | 18 +
 rtl/ringoscillator_prescaler.sv | 19 +
 rtl/ringoscillator_freqmeter.sv | 124 ++++++++++++
 tb/tb_ringoscillator_freqmeter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringoscillator_pkg.sv
// Shared FSM encoding and timing constants for the ring-oscillator frequency meter.
package ringoscillator_pkg;

  localparam int SETTLE_CYCLES = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Down-counter width large enough to hold the longer of the two load values.
  function automatic int timer_width(input int gate_cycles);
    int n;
    n = (gate_cycles > SETTLE_CYCLES) ? gate_cycles : SETTLE_CYCLES;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ringoscillator_prescaler.sv
// Free-running divider clocked by the ring oscillator; the MSB toggles at
// osc_in / 2**PRESCALE_LOG2. Only used when RINGOSC_FREQMETER_PRESCALER_EN is defined.
module ringoscillator_prescaler #(
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic i_osc,
  output logic o_div
);

  // No reset: rst_n lives in the clk domain, so only a power-up value is given.
  logic [PRESCALE_LOG2-1:0] r_cnt = '0;

  always_ff @(posedge i_osc) begin
    r_cnt <= r_cnt + 1'b1;
  end

  assign o_div = r_cnt[PRESCALE_LOG2-1];

endmodule

// File: rtl/ringoscillator_freqmeter.sv
// Gated rising-edge counter for an asynchronous ring-oscillator output.
// Optional osc_in prescaler enabled by defining RINGOSC_FREQMETER_PRESCALER_EN.
//
// state  | meaning
// IDLE   | waiting for start; result holds the last count
// SETTLE | 4 cycles flushing the synchronizer, edges discarded
// GATE   | counting synchronized rising edges for GATE_CYCLES cycles
// HOLD   | result_valid high until result_ready
//
// Inputs faster than one period per 3 clk cycles undercount; this is not detected.
module ringoscillator_freqmeter
  import ringoscillator_pkg::*;
#(
  parameter int GATE_CYCLES   = 1024,
  parameter int COUNT_WIDTH   = 16,
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   osc_in,
  input  logic                   start,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overflow
);

  localparam int                 TIMER_W     = timer_width(GATE_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GATE_LOAD   = TIMER_W'(GATE_CYCLES - 1);

  generate
    if (GATE_CYCLES < 1 || COUNT_WIDTH < 4 || PRESCALE_LOG2 < 1) begin : g_bad_param
      $error("ringoscillator_freqmeter: parameter out of range");
    end
  endgenerate

  logic                   w_meas;
  logic                   w_rise;
  logic                   w_tc;
  logic                   w_sat;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_hist;
  logic [1:0]             r_state;
  logic [TIMER_W-1:0]     r_timer;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_overflow;

`ifdef RINGOSC_FREQMETER_PRESCALER_EN
  ringoscillator_prescaler #(
    .PRESCALE_LOG2(PRESCALE_LOG2)
  ) u_prescaler (
    .i_osc(osc_in),
    .o_div(w_meas)
  );
`else
  assign w_meas = osc_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= w_meas;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_hist;
  assign w_tc   = (r_timer == '0);
  assign w_sat  = &r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SETTLE;
            r_timer    <= SETTLE_LOAD;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_tc) begin
            r_state <= ST_GATE;
            r_timer <= GATE_LOAD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_GATE: begin
          // Saturate rather than wrap; overflow flags the lost edges.
          if (w_rise) begin
            if (w_sat) r_overflow <= 1'b1;
            else       r_count    <= r_count + 1'b1;
          end
          if (w_tc) r_state <= ST_HOLD;
          else      r_timer <= r_timer - 1'b1;
        end
        ST_HOLD: begin
          if (result_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign result_valid = (r_state == ST_HOLD);
  assign result       = r_count;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_ringoscillator_freqmeter.sv
// Self-checking bench for ringoscillator_freqmeter; the prescaler scenario runs
// only when RINGOSC_FREQMETER_PRESCALER_EN is defined.
module tb_ringoscillator_freqmeter;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t q_pre[$];

  int n_pass  = 0;
  int n_total = 0;

  logic clk          = 1'b0;
  logic rst_n        = 1'b0;
  logic start        = 1'b0;
  logic result_ready = 1'b0;
  logic osc_a        = 1'b0;
  int   osc_mode     = 0;

  logic        busy_m, valid_m, ovf_m;
  logic [15:0] res_m;
  logic        busy_s, valid_s, ovf_s;
  logic [3:0]  res_s;

  ringoscillator_freqmeter #(.GATE_CYCLES(100), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_a), .start(start),
    .busy(busy_m), .result(res_m), .result_valid(valid_m),
    .result_ready(result_ready), .overflow(ovf_m)
  );

  ringoscillator_freqmeter #(.GATE_CYCLES(100), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_a), .start(start),
    .busy(busy_s), .result(res_s), .result_valid(valid_s),
    .result_ready(result_ready), .overflow(ovf_s)
  );

`ifdef RINGOSC_FREQMETER_PRESCALER_EN
  logic        osc_fast = 1'b0;
  logic        busy_p, valid_p, ovf_p;
  logic [15:0] res_p;

  ringoscillator_freqmeter #(.GATE_CYCLES(256), .COUNT_WIDTH(16), .PRESCALE_LOG2(4)) dut_pre (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_fast), .start(start),
    .busy(busy_p), .result(res_p), .result_valid(valid_p),
    .result_ready(result_ready), .overflow(ovf_p)
  );

  // Half a clk period.
  always #5 osc_fast = ~osc_fast;
`endif

  // clk period 20; posedges at 10 mod 20, osc toggles only at multiples of 20.
  always #10 clk = ~clk;

  always begin
    if (osc_mode == 2) begin
      osc_a = 1'b1;
      #40;
      osc_a = 1'b0;
      #40;
    end else begin
      osc_a = (osc_mode == 1);
      #20;
    end
  end

  function automatic logic valid_of(input int sel);
`ifdef RINGOSC_FREQMETER_PRESCALER_EN
    if (sel == 2) return valid_p;
`endif
    return (sel == 1) ? valid_s : valid_m;
  endfunction

  // Drives start so it is sampled at the next posedge (cycle count 1 = that edge).
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts posedges from the start-sampling edge until result_valid is seen.
  task automatic wait_valid(input int sel, input int budget, input bit pulse,
                            output int cyc, output bit to);
    cyc = 1;
    to  = 1'b0;
    forever begin
      @(negedge clk);
      start = pulse && (cyc >= 20) && (cyc < 60) && (cyc % 4 == 0);
      if (valid_of(sel)) break;
      if (cyc >= budget) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bit to;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; result_ready = 1'b0; osc_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_m); else n_pass++;
    n_total++; if (valid_m !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_m); else n_pass++;
    n_total++; if (res_m !== 16'd0) $display("FAIL reset_result: got %0d want 0", res_m); else n_pass++;
    n_total++; if (ovf_m !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_m); else n_pass++;
    n_total++; if (busy_s !== 1'b0 || valid_s !== 1'b0) $display("FAIL reset_sat_flags: got busy %b valid %b want 0 0", busy_s, valid_s); else n_pass++;
    // Start presented together with reset release is taken on that first edge.
    q_main.push_back('{0, 0, 1'b0});
    q_sat.push_back('{0, 0, 1'b0});
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(0, 400, 1'b0, cyc, to);
    n_total++; if (to) $display("FAIL reset_start_timeout: got no valid want valid"); else n_pass++;
    n_total++; if (cyc !== 105) $display("FAIL reset_start_latency: got %0d want 105", cyc); else n_pass++;
    e = q_main.pop_front();
    n_total++; if (int'(res_m) < e.lo || int'(res_m) > e.hi) $display("FAIL reset_start_result: got %0d want %0d..%0d", res_m, e.lo, e.hi); else n_pass++;
    e = q_sat.pop_front();
    n_total++; if (int'(res_s) < e.lo || int'(res_s) > e.hi || ovf_s !== e.ovf) $display("FAIL reset_start_sat: got %0d/%b want %0d/%b", res_s, ovf_s, e.lo, e.ovf); else n_pass++;
    handshake();
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    exp_t e;
    osc_mode = 2;
    repeat (10) @(negedge clk);
    q_main.push_back('{24, 26, 1'b0});
    q_sat.push_back('{15, 15, 1'b1});
    launch();
    wait_valid(0, 400, 1'b0, cyc, to);
    n_total++; if (to) $display("FAIL basic_timeout: got no valid want valid"); else n_pass++;
    n_total++; if (cyc !== 105) $display("FAIL basic_latency: got %0d want 105", cyc); else n_pass++;
    e = q_main.pop_front();
    n_total++; if (int'(res_m) < e.lo || int'(res_m) > e.hi) $display("FAIL basic_result: got %0d want %0d..%0d", res_m, e.lo, e.hi); else n_pass++;
    n_total++; if (ovf_m !== e.ovf) $display("FAIL basic_ovf: got %b want %b", ovf_m, e.ovf); else n_pass++;
    e = q_sat.pop_front();
    n_total++; if (valid_s !== 1'b1) $display("FAIL sat_valid: got %b want 1", valid_s); else n_pass++;
    n_total++; if (int'(res_s) < e.lo || int'(res_s) > e.hi) $display("FAIL sat_result: got %0d want %0d", res_s, e.lo); else n_pass++;
    n_total++; if (ovf_s !== e.ovf) $display("FAIL sat_ovf: got %b want %b", ovf_s, e.ovf); else n_pass++;
    handshake();
    @(negedge clk);
    n_total++; if (busy_m !== 1'b0 || valid_m !== 1'b0) $display("FAIL basic_release: got busy %b valid %b want 0 0", busy_m, valid_m); else n_pass++;
  endtask

  task automatic test_hold_stall();
    int cyc;
    bit to;
    exp_t e;
    osc_mode = 2;
    q_main.push_back('{24, 26, 1'b0});
    q_sat.push_back('{15, 15, 1'b1});
    launch();
    // Stray start pulses during GATE must not restart or extend the window.
    wait_valid(0, 400, 1'b1, cyc, to);
    n_total++; if (to) $display("FAIL stall_timeout: got no valid want valid"); else n_pass++;
    n_total++; if (cyc !== 105) $display("FAIL stall_latency: got %0d want 105", cyc); else n_pass++;
    e = q_main.pop_front();
    for (int i = 0; i < 50; i++) begin
      n_total++;
      if (valid_m !== 1'b1 || int'(res_m) < e.lo || int'(res_m) > e.hi || ovf_m !== e.ovf)
        $display("FAIL stall_hold_%0d: got valid %b result %0d want 1 %0d..%0d", i, valid_m, res_m, e.lo, e.hi);
      else n_pass++;
      @(negedge clk);
    end
    e = q_sat.pop_front();
    n_total++; if (res_s !== 4'(e.lo) || ovf_s !== e.ovf || valid_s !== 1'b1) $display("FAIL stall_sat: got %0d/%b want %0d/%b", res_s, ovf_s, e.lo, e.ovf); else n_pass++;
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    n_total++; if (busy_m !== 1'b0) $display("FAIL stall_release: got busy %b want 0", busy_m); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (busy_m !== 1'b0 || busy_s !== 1'b0) $display("FAIL hold_start_ignored: got busy %b %b want 0 0", busy_m, busy_s); else n_pass++;
  endtask

  task automatic test_reset_mid_gate();
    int cyc;
    bit to;
    exp_t e;
    osc_mode = 2;
    launch();
    repeat (44) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (busy_m !== 1'b0 || valid_m !== 1'b0) $display("FAIL midreset_flags: got busy %b valid %b want 0 0", busy_m, valid_m); else n_pass++;
    n_total++; if (res_m !== 16'd0 || ovf_m !== 1'b0) $display("FAIL midreset_result: got %0d/%b want 0/0", res_m, ovf_m); else n_pass++;
    n_total++; if (busy_s !== 1'b0 || res_s !== 4'd0) $display("FAIL midreset_sat: got busy %b result %0d want 0 0", busy_s, res_s); else n_pass++;
    q_main.push_back('{24, 26, 1'b0});
    q_sat.push_back('{15, 15, 1'b1});
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(0, 400, 1'b0, cyc, to);
    n_total++; if (to) $display("FAIL midreset_timeout: got no valid want valid"); else n_pass++;
    n_total++; if (cyc !== 105) $display("FAIL midreset_latency: got %0d want 105", cyc); else n_pass++;
    e = q_main.pop_front();
    n_total++; if (int'(res_m) < e.lo || int'(res_m) > e.hi) $display("FAIL midreset_full_result: got %0d want %0d..%0d", res_m, e.lo, e.hi); else n_pass++;
    e = q_sat.pop_front();
    n_total++; if (res_s !== 4'(e.lo) || ovf_s !== e.ovf) $display("FAIL midreset_sat_result: got %0d/%b want %0d/%b", res_s, ovf_s, e.lo, e.ovf); else n_pass++;
    handshake();
  endtask

  task automatic test_constant();
    int cyc;
    bit to;
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      osc_mode = m;
      repeat (10) @(negedge clk);
      q_main.push_back('{0, 0, 1'b0});
      q_sat.push_back('{0, 0, 1'b0});
      launch();
      wait_valid(0, 400, 1'b0, cyc, to);
      n_total++; if (to) $display("FAIL const%0d_timeout: got no valid want valid", m); else n_pass++;
      e = q_main.pop_front();
      n_total++; if (int'(res_m) != e.lo || ovf_m !== e.ovf) $display("FAIL const%0d_result: got %0d/%b want %0d/%b", m, res_m, ovf_m, e.lo, e.ovf); else n_pass++;
      e = q_sat.pop_front();
      n_total++; if (int'(res_s) != e.lo || ovf_s !== e.ovf) $display("FAIL const%0d_sat: got %0d/%b want %0d/%b", m, res_s, ovf_s, e.lo, e.ovf); else n_pass++;
      handshake();
    end
  endtask

`ifdef RINGOSC_FREQMETER_PRESCALER_EN
  task automatic test_prescaler();
    int cyc;
    bit to;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    q_pre.push_back('{31, 33, 1'b0});
    launch();
    wait_valid(2, 600, 1'b0, cyc, to);
    n_total++; if (to) $display("FAIL pre_timeout: got no valid want valid"); else n_pass++;
    n_total++; if (cyc !== 261) $display("FAIL pre_latency: got %0d want 261", cyc); else n_pass++;
    e = q_pre.pop_front();
    n_total++; if (int'(res_p) < e.lo || int'(res_p) > e.hi) $display("FAIL pre_result: got %0d want %0d..%0d", res_p, e.lo, e.hi); else n_pass++;
    n_total++; if (ovf_p !== e.ovf) $display("FAIL pre_ovf: got %b want %b", ovf_p, e.ovf); else n_pass++;
    handshake();
  endtask
`endif

  initial begin
    test_reset();
`ifdef RINGOSC_FREQMETER_PRESCALER_EN
    test_prescaler();
`else
    test_basic();
    test_hold_stall();
    test_reset_mid_gate();
    test_constant();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
